q_func_sched: RTL and testbench

// - Round-robin scheduler sharing one Q-function datapath (int->float, ln, divide, sqrt, add, x10, float->fix) among NUM_REQ requesters.
// - Sits between requester ports and the datapath's AXI-stream style operand/result handshake.
// - Tags each issued job with its requester ID and routes the in-order result back to that requester.
// - Detects lost results with a no-progress timeout.

---
 rtl/q_func_pkg.sv | 21 ++
 rtl/q_tag_fifo.sv | 56 +++++
 rtl/q_func_sched.sv | 211 +++++++++++++++++++++
 tb/tb_q_func_sched.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_func_pkg.sv
// Shared types for the Q-function scheduler: tag, FSM state,
// result width and the response buffer entry.
package q_func_pkg;

  localparam int Q_W     = 32;
  localparam int MAX_REQ = 8;
  localparam int TAG_W   = $clog2(MAX_REQ);

  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } state_e;

  typedef struct packed {
    tag_t           tag;
    logic [Q_W-1:0] q;
  } rsp_t;

endpackage

// File: rtl/q_tag_fifo.sv
// Tag FIFO holding requester IDs of jobs in flight, in issue order.
// Ports: push/din, pop/dout, flush, full, empty, count.
module q_tag_fifo
  import q_func_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  tag_t          din,
  input  logic          pop,
  input  logic          flush,
  output tag_t          dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  tag_t          mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/q_func_sched.sv
// Round-robin scheduler sharing one Q-function datapath among requesters.
// Ports: req_* in, rsp_* out, dp_* to datapath, clr_err/busy/err_* status.
module q_func_sched
  import q_func_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_OUT     = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [Q_W*NUM_REQ-1:0] req_x,
  input  logic [Q_W*NUM_REQ-1:0] req_n,
  input  logic [Q_W*NUM_REQ-1:0] req_t,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [Q_W-1:0]         rsp_q,
  output logic                   dp_in_valid,
  input  logic                   dp_in_ready,
  output logic [Q_W-1:0]         dp_x,
  output logic [Q_W-1:0]         dp_n,
  output logic [Q_W-1:0]         dp_t,
  input  logic                   dp_out_valid,
  output logic                   dp_out_ready,
  input  logic [Q_W-1:0]         dp_out_q,
  input  logic                   clr_err,
  output logic                   busy,
  output logic                   err_timeout,
  output logic                   err_orphan
);

  localparam int CW = $clog2(MAX_OUT) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e        state_q, state_d;
  tag_t          rr_q, rr_d;
  tag_t          gnt_q, gnt_d;
  logic          lock_q, lock_d;
  logic          buf_vld_q, buf_vld_d;
  rsp_t          buf_q, buf_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          eto_q, eto_d;
  logic          eor_q, eor_d;

  logic [NUM_REQ-1:0] rot;
  tag_t          arb;
  tag_t          g;
  logic          buf_rdy;
  logic          issue;
  logic          acc;
  logic          pop;
  logic          orphan;
  logic          flush;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  tag_t          fifo_tag;
  logic          tmo_hit;

  q_tag_fifo #(.DEPTH(MAX_OUT)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (issue),
    .din   (g),
    .pop   (pop),
    .flush (flush),
    .dout  (fifo_tag),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // rot[k] is the request at offset k from the rr pointer
  always_comb begin
    int off;
    int s;
    rot = NUM_REQ'({req_valid, req_valid} >> rr_q);
    off = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    s = int'(rr_q) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    arb = tag_t'(s);
    // a stalled handshake keeps its grant
    g = lock_q ? gnt_q : arb;
  end

  always_comb begin
    dp_x = '0;
    dp_n = '0;
    dp_t = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g == tag_t'(i)) begin
        dp_x = req_x[Q_W*i +: Q_W];
        dp_n = req_n[Q_W*i +: Q_W];
        dp_t = req_t[Q_W*i +: Q_W];
      end
    end
  end

  always_comb begin
    buf_rdy   = 1'b0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (buf_q.tag == tag_t'(i)) begin
        buf_rdy      = rsp_ready[i];
        rsp_valid[i] = buf_vld_q;
      end
    end
  end

  assign rsp_q       = buf_q.q;
  assign issue       = dp_in_valid & dp_in_ready;
  assign acc         = dp_out_valid & dp_out_ready;
  assign pop         = acc & ~empty & (state_q == RUN);
  assign orphan      = acc & empty & (state_q == RUN);
  assign tmo_hit     = (tmo_q == TW'(TIMEOUT_CYC));
  assign busy        = (count != '0) | buf_vld_q;
  assign err_timeout = eto_q;
  assign err_orphan  = eor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: if (tmo_hit) state_d = ERR;
      ERR: if (clr_err) state_d = RUN;
    endcase
  end

  always_comb begin
    dp_in_valid  = 1'b0;
    dp_out_ready = 1'b1;
    flush        = 1'b0;
    req_ready    = '0;
    unique case (state_q)
      RUN: begin
        dp_in_valid  = |req_valid & ~full;
        dp_out_ready = ~buf_vld_q | buf_rdy;
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = issue & (g == tag_t'(i));
        end
      end
      ERR: flush = 1'b1;
    endcase
  end

  always_comb begin
    rr_d      = rr_q;
    gnt_d     = g;
    lock_d    = dp_in_valid & ~dp_in_ready;
    buf_vld_d = buf_vld_q;
    buf_d     = buf_q;
    tmo_d     = tmo_q;
    eto_d     = eto_q | ((state_q == RUN) & tmo_hit);
    eor_d     = eor_q | orphan;

    if (issue) begin
      rr_d = (g == tag_t'(NUM_REQ - 1)) ? '0 : g + 1'b1;
    end

    if (state_q == ERR || acc || empty) tmo_d = '0;
    else if (!tmo_hit)                  tmo_d = tmo_q + 1'b1;

    if (state_q == ERR) begin
      buf_vld_d = 1'b0;
      buf_d     = '0;
    end else begin
      if (buf_vld_q && buf_rdy) buf_vld_d = 1'b0;
      if (pop) begin
        buf_vld_d = 1'b1;
        buf_d     = '{tag: fifo_tag, q: dp_out_q};
      end
    end

    if (clr_err) begin
      eto_d = 1'b0;
      eor_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= '0;
      gnt_q     <= '0;
      lock_q    <= 1'b0;
      buf_vld_q <= 1'b0;
      buf_q     <= '0;
      tmo_q     <= '0;
      eto_q     <= 1'b0;
      eor_q     <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      lock_q    <= lock_d;
      buf_vld_q <= buf_vld_d;
      buf_q     <= buf_d;
      tmo_q     <= tmo_d;
      eto_q     <= eto_d;
      eor_q     <= eor_d;
    end
  end

endmodule

// File: tb/tb_q_func_sched.sv
// Directed bench for q_func_sched with a latency stub datapath
// and a response scoreboard.
module tb_q_func_sched;

  localparam int N   = 4;
  localparam int LAT = 30;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_x, req_n, req_t;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [31:0]     rsp_q;
  logic            dp_in_valid, dp_in_ready;
  logic [31:0]     dp_x, dp_n, dp_t;
  logic            dp_out_valid, dp_out_ready;
  logic [31:0]     dp_out_q;
  logic            clr_err, busy, err_timeout, err_orphan;

  logic        stub_en, stub_v, man_v;
  logic [31:0] stub_q, man_q;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  typedef struct { int tag; logic [31:0] q; } exp_t;
  typedef struct { int due; logic [31:0] q; } job_t;
  exp_t sb[$];
  job_t pipe[$];

  assign dp_out_valid = stub_en ? stub_v : man_v;
  assign dp_out_q     = stub_en ? stub_q : man_q;

  q_func_sched #(.NUM_REQ(N), .MAX_OUT(8), .TIMEOUT_CYC(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_n(req_n), .req_t(req_t),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q),
    .dp_in_valid(dp_in_valid), .dp_in_ready(dp_in_ready),
    .dp_x(dp_x), .dp_n(dp_n), .dp_t(dp_t),
    .dp_out_valid(dp_out_valid), .dp_out_ready(dp_out_ready),
    .dp_out_q(dp_out_q),
    .clr_err(clr_err), .busy(busy),
    .err_timeout(err_timeout), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] qf(logic [31:0] x, logic [31:0] n,
                                     logic [31:0] t);
    return (x ^ {n[15:0], n[31:16]}) + (t << 1) + t;
  endfunction

  function automatic logic [31:0] opx(int i);
    return req_x[32*i +: 32];
  endfunction

  function automatic logic [31:0] exp_q(int i);
    return qf(req_x[32*i +: 32], req_n[32*i +: 32], req_t[32*i +: 32]);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_valid   = '0;
    rsp_ready   = '0;
    dp_in_ready = 1'b0;
    man_v       = 1'b0;
    man_q       = '0;
    clr_err     = 1'b0;
    stub_en     = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  // latency stub: capture issues, present results in order
  always @(negedge clk) begin
    if (!rst_n) pipe.delete();
    else if (stub_en) begin
      if (dp_out_valid && dp_out_ready && pipe.size() > 0)
        void'(pipe.pop_front());
      if (dp_in_valid && dp_in_ready)
        pipe.push_back('{cyc + LAT, qf(dp_x, dp_n, dp_t)});
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    stub_v = stub_en && pipe.size() > 0 && pipe[0].due <= cyc;
    stub_q = stub_v ? pipe[0].q : '0;
  end

  // scoreboard: every response handshake must match the queue head
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && |(rsp_valid & rsp_ready)) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_onehot", 32'(rsp_valid), 1 << e.tag);
        chk("rsp_q", rsp_q, e.q);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n   = 1'b0;
    stub_en = 1'b0;
    stub_v  = 1'b0;
    stub_q  = '0;
    for (int i = 0; i < N; i++) begin
      req_x[32*i +: 32] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      req_n[32*i +: 32] = 32'h0000_0100 + 32'(i);
      req_t[32*i +: 32] = 32'h0BAD_0000 ^ 32'(i * 7);
    end

    // reset state
    do_reset();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_q", rsp_q, 0);
    chk("rst_dp_in_valid", 32'(dp_in_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err_to", 32'(err_timeout), 0);
    chk("rst_err_or", 32'(err_orphan), 0);

    // alternating grants 0,2,0,2 then drain results in order
    dp_in_ready = 1'b1;
    rsp_ready   = '1;
    req_valid   = 4'b0101;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t1_grant", 32'(req_ready), (k % 2) ? 4 : 1);
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      man_v = 1'b1;
      man_q = 32'hA000 + 32'(k);
      sb.push_back('{(k % 2) ? 2 : 0, man_q});
      tick();
    end
    man_v = 1'b0;
    tick();
    tick();
    chk("t1_drain", sb.size(), 0);
    chk("t1_busy", 32'(busy), 0);

    // four requesters through a 30-cycle datapath
    do_reset();
    stub_en     = 1'b1;
    dp_in_ready = 1'b1;
    rsp_ready   = '1;
    for (int i = 0; i < N; i++) sb.push_back('{i, exp_q(i)});
    req_valid = '1;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("t2_grant", 32'(req_ready), 1 << k);
      tick();
      req_valid[k] = 1'b0;
      #1;
    end
    w = 0;
    while (sb.size() > 0 && w < 100) begin
      tick();
      w++;
    end
    chk("t2_drain", sb.size(), 0);
    stub_en = 1'b0;
    tick();
    chk("t2_busy", 32'(busy), 0);

    // stalled handshake holds grant and operands
    do_reset();
    req_valid = 4'b0110;
    #1;
    chk("t3_dpv", 32'(dp_in_valid), 1);
    chk("t3_dpx0", dp_x, opx(1));
    for (int k = 0; k < 5; k++) begin
      tick();
      req_valid = 4'b0111;
      #1;
      chk("t3_dpx", dp_x, opx(1));
      chk("t3_rdy", 32'(req_ready), 0);
    end
    dp_in_ready = 1'b1;
    #1;
    chk("t3_acc", 32'(req_ready), 2);
    tick();
    chk("t3_next", 32'(req_ready), 4);
    req_valid = '0;
    tick();

    // fill the tag FIFO, then one result frees one slot
    do_reset();
    dp_in_ready = 1'b1;
    rsp_ready   = '1;
    req_valid   = '1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("t4_grant", 32'(req_ready), 1 << (k % 4));
      tick();
    end
    chk("t4_full", 32'(req_ready), 0);
    chk("t4_dpv", 32'(dp_in_valid), 0);
    man_v = 1'b1;
    man_q = 32'h4444;
    sb.push_back('{0, 32'h4444});
    tick();
    man_v = 1'b0;
    #1;
    chk("t4_reissue", 32'(req_ready), 1);
    tick();
    chk("t4_full2", 32'(req_ready), 0);
    req_valid = '0;
    tick();
    chk("t4_rsp", sb.size(), 0);

    // response backpressure
    do_reset();
    dp_in_ready = 1'b1;
    req_valid   = 4'b0010;
    #1;
    tick();
    req_valid = '0;
    man_v     = 1'b1;
    man_q     = 32'hABCD_1234;
    sb.push_back('{1, 32'hABCD_1234});
    tick();
    man_v = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t5_vld", 32'(rsp_valid), 2);
      chk("t5_q", rsp_q, 32'hABCD_1234);
      chk("t5_dpr", 32'(dp_out_ready), 0);
      tick();
    end
    rsp_ready = 4'b0010;
    #1;
    chk("t5_dpr1", 32'(dp_out_ready), 1);
    tick();
    chk("t5_gone", 32'(rsp_valid), 0);
    chk("t5_sb", sb.size(), 0);

    // timeout with one job in flight
    do_reset();
    dp_in_ready = 1'b1;
    rsp_ready   = '1;
    req_valid   = 4'b0001;
    #1;
    tick();
    req_valid = '0;
    repeat (250) tick();
    chk("t6_early", 32'(err_timeout), 0);
    w = 0;
    while (!err_timeout && w < 30) begin
      tick();
      w++;
    end
    chk("t6_to", 32'(err_timeout), 1);
    req_valid = 4'b0001;
    #1;
    chk("t6_err_rdy", 32'(req_ready), 0);
    chk("t6_err_dpv", 32'(dp_in_valid), 0);
    chk("t6_err_dpr", 32'(dp_out_ready), 1);
    tick();
    chk("t6_flush", 32'(busy), 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    #1;
    chk("t6_clr", 32'(err_timeout), 0);
    chk("t6_run", 32'(req_ready), 1);
    chk("t6_busy", 32'(busy), 0);
    req_valid = '0;
    #1;

    // orphan result with nothing in flight
    man_v = 1'b1;
    man_q = 32'h55;
    tick();
    man_v = 1'b0;
    #1;
    chk("t7_orphan", 32'(err_orphan), 1);
    chk("t7_norsp", 32'(rsp_valid), 0);
    req_valid = 4'b0001;
    #1;
    chk("t7_run", 32'(dp_in_valid), 1);
    req_valid = '0;
    clr_err   = 1'b1;
    tick();
    clr_err = 1'b0;
    #1;
    chk("t7_clr", 32'(err_orphan), 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
